// File: rtl/burst_master.sv
// burst_master: turns single-line read/write requests into fixed-length RAM
// bursts.
//
// A request carries one line of BURST_COUNT words. The RAM address is aligned
// down to a BURST_COUNT boundary. Word i of the line goes to (or comes from)
// the aligned address + i.
//
// Optional feature (macro BURST_MASTER_TIMEOUT_EN):
//   A watchdog runs in RD_WAIT. If no read data arrives within TIMEOUT_CYCLES
//   cycles, the read completes with resp_err=1 and resp_line is left unchanged.
//   Without the macro the block waits forever and resp_err is tied to 0.
//
// Ports:
//   clk, rst             single clock, synchronous active-low reset
//   req_*                request channel (valid/ready handshake, write line in)
//   resp_valid/line/err  one-cycle completion pulse, read line, timeout flag
//   ram_cmd/_en/addr     burst command to the RAM (one strobe per request)
//   ram_wr_data          write word, one per cycle starting at the command cycle
//   ram_data_mask        always 0 (full-word writes)
//   ram_rd_data/_ready   read word stream from the RAM
//   ram_busy             RAM cannot accept a command this cycle
module burst_master #(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int DATA_BITWIDTH  = 64,
    parameter int BURST_COUNT    = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req_valid,
    input  logic                                  req_write,
    input  logic [DEPTH_BITWIDTH-1:0]             req_addr,
    input  logic [DATA_BITWIDTH*BURST_COUNT-1:0]  req_line,
    output logic                                  req_ready,
    output logic                                  resp_valid,
    output logic [DATA_BITWIDTH*BURST_COUNT-1:0]  resp_line,
    output logic                                  resp_err,
    output logic                                  ram_cmd,
    output logic                                  ram_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]             ram_addr,
    output logic [DATA_BITWIDTH-1:0]              ram_wr_data,
    output logic [DATA_BITWIDTH/8-1:0]            ram_data_mask,
    input  logic [DATA_BITWIDTH-1:0]              ram_rd_data,
    input  logic                                  ram_rd_data_ready,
    input  logic                                  ram_busy
);

    localparam int LINE_W = DATA_BITWIDTH * BURST_COUNT;
    localparam int CNT_W  = $clog2(BURST_COUNT);
    localparam logic [DEPTH_BITWIDTH-1:0] ALIGN_MASK = ~(DEPTH_BITWIDTH'(BURST_COUNT - 1));

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WR_BURST,
        RD_WAIT,
        RD_BURST,
        DONE
    } state_t;

    state_t             state;
    logic               is_write;
    logic [LINE_W-1:0]  wr_line;
    logic [LINE_W-1:0]  rd_buf;
    logic [LINE_W-1:0]  rd_next;
    logic [CNT_W-1:0]   cnt;
    logic               last_word;

`ifdef BURST_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]    to_cnt;
`else
    assign resp_err = 1'b0;
`endif

    assign req_ready     = (state == IDLE);
    // The command strobe has to land in the very cycle busy is low, so it is
    // decoded from the state register and the live busy input.
    assign ram_cmd_en    = (state == ISSUE) && !ram_busy;
    assign ram_data_mask = '0;
    assign last_word     = (cnt == CNT_W'(BURST_COUNT - 1));

    // Capture buffer with the incoming word merged in at the current slot.
    // Kept separate from resp_line so the previous read result stays stable
    // while a new read burst is streaming in.
    always_comb begin
        rd_next = rd_buf;
        rd_next[int'(cnt) * DATA_BITWIDTH +: DATA_BITWIDTH] = ram_rd_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            is_write    <= 1'b0;
            wr_line     <= '0;
            rd_buf      <= '0;
            cnt         <= '0;
            ram_cmd     <= 1'b0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
            resp_valid  <= 1'b0;
            resp_line   <= '0;
`ifdef BURST_MASTER_TIMEOUT_EN
            to_cnt      <= '0;
            resp_err    <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
`ifdef BURST_MASTER_TIMEOUT_EN
            resp_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        is_write    <= req_write;
                        wr_line     <= req_line;
                        ram_cmd     <= req_write;
                        ram_addr    <= req_addr & ALIGN_MASK;
                        // Word 0 must already be on the bus in the command cycle.
                        ram_wr_data <= req_line[DATA_BITWIDTH-1:0];
                        cnt         <= '0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!ram_busy) begin
                        if (is_write) begin
                            ram_wr_data <= wr_line[DATA_BITWIDTH +: DATA_BITWIDTH];
                            cnt         <= CNT_W'(1);
                            state       <= WR_BURST;
                        end else begin
                            cnt   <= '0;
                            state <= RD_WAIT;
`ifdef BURST_MASTER_TIMEOUT_EN
                            to_cnt <= '0;
`endif
                        end
                    end
                end
                WR_BURST: begin
                    // cnt is the index of the word currently on ram_wr_data.
                    if (last_word) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                    end else begin
                        ram_wr_data <= wr_line[(int'(cnt) + 1) * DATA_BITWIDTH +: DATA_BITWIDTH];
                        cnt         <= cnt + CNT_W'(1);
                    end
                end
                RD_WAIT: begin
                    if (ram_rd_data_ready) begin
                        // BURST_COUNT >= 2, so the first word is never the last.
                        rd_buf <= rd_next;
                        cnt    <= cnt + CNT_W'(1);
                        state  <= RD_BURST;
                    end
`ifdef BURST_MASTER_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                RD_BURST: begin
                    // Gaps in ram_rd_data_ready simply stall the capture.
                    if (ram_rd_data_ready) begin
                        rd_buf <= rd_next;
                        cnt    <= cnt + CNT_W'(1);
                        if (last_word) begin
                            resp_line  <= rd_next;
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_master.sv
// Testbench for burst_master: a small RAM model drives the RAM side and a
// transaction-level reference model predicts every DUT output cycle by cycle.
module tb_burst_master;

    localparam int AW = 4;
    localparam int DW = 64;
    localparam int BC = 4;
    localparam int LW = DW * BC;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [LW-1:0] req_line  = '0;
    logic          req_ready;
    logic          resp_valid;
    logic [LW-1:0] resp_line;
    logic          resp_err;
    logic          ram_cmd;
    logic          ram_cmd_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr_data;
    logic [DW/8-1:0] ram_data_mask;
    logic [DW-1:0] ram_rd_data = '0;
    logic          ram_rd_data_ready = 1'b0;
    logic          ram_busy = 1'b1;

    always #5 clk = ~clk;

    burst_master #(
        .DEPTH_BITWIDTH(AW),
        .DATA_BITWIDTH (DW),
        .BURST_COUNT   (BC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_line         (req_line),
        .req_ready        (req_ready),
        .resp_valid       (resp_valid),
        .resp_line        (resp_line),
        .resp_err         (resp_err),
        .ram_cmd          (ram_cmd),
        .ram_cmd_en       (ram_cmd_en),
        .ram_addr         (ram_addr),
        .ram_wr_data      (ram_wr_data),
        .ram_data_mask    (ram_data_mask),
        .ram_rd_data      (ram_rd_data),
        .ram_rd_data_ready(ram_rd_data_ready),
        .ram_busy         (ram_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event did not occur within cycle bound", name);
    endtask

    // ---------------- RAM model ----------------
    logic [DW-1:0] mem [16];
    int            init_cnt = 0;
    int            rd_wait = 0;
    int            rd_left = 0;
    int            wr_left = 0;
    logic [AW-1:0] rd_ptr = '0;
    logic [AW-1:0] wr_ptr = '0;
    bit            force_no_rd = 0;
    bit            no_gap = 0;

    // Command and write-word capture, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            wr_left = 0;
            rd_left = 0;
        end else begin
            if (wr_left > 0) begin
                mem[wr_ptr] = ram_wr_data;
                wr_ptr++;
                wr_left--;
            end
            if (ram_cmd_en) begin
                if (ram_cmd) begin
                    mem[ram_addr] = ram_wr_data;
                    wr_ptr  = ram_addr + 4'd1;
                    wr_left = BC - 1;
                end else begin
                    rd_ptr  = ram_addr;
                    rd_wait = 8;
                    rd_left = BC;
                end
            end
        end
    end

    // Busy / read-data drive for the new cycle.
    always @(posedge clk) begin
        #1;
        ram_rd_data_ready = 1'b0;
        ram_rd_data = {$urandom, $urandom};
        if (!rst) begin
            init_cnt = 0;
            ram_busy = 1'b1;
        end else begin
            if (init_cnt < 10) begin
                init_cnt++;
                ram_busy = 1'b1;
            end else begin
                ram_busy = ($urandom_range(3) == 0);
            end
            if (force_no_rd) begin
                ram_rd_data_ready = 1'b0;
            end else if (rd_left > 0) begin
                if (rd_wait > 0) rd_wait--;
                else if (no_gap || $urandom_range(3) != 0) begin
                    ram_rd_data_ready = 1'b1;
                    ram_rd_data = mem[rd_ptr];
                    rd_ptr++;
                    rd_left--;
                end
            end else if ($urandom_range(7) == 0) begin
                // stray strobe with junk data; the DUT must ignore it
                ram_rd_data_ready = 1'b1;
            end
        end
    end

    // ---------------- reference model + compare ----------------
    logic [DW-1:0] ref_mem [16];
    int            cyc = 0;
    bit            prev_rst = 0;
    bit            pend = 0, issued = 0, m_wr = 0, m_err = 0;
    int            m_addr = 0, issue_cyc = 0, done_cyc = -1, rd_cnt = 0;
    logic [LW-1:0] m_line = '0, m_cap = '0, m_exp_rd = '0, m_resp_line = '0;
    bit            exp_cmd, exp_rv;

    always @(negedge clk) begin
        cyc++;
        exp_rv = 0;
        if (!prev_rst) begin
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_err", resp_err, 0);
            chk("rst_resp_line", resp_line, 0);
            chk("rst_cmd_en", ram_cmd_en, 0);
            chk("rst_cmd", ram_cmd, 0);
            chk("rst_addr", ram_addr, 0);
            chk("rst_wr_data", ram_wr_data, 0);
            chk("rst_mask", ram_data_mask, 0);
            chk("rst_req_ready", req_ready, 1);
            m_resp_line = '0;
            pend = 0;
        end else begin
            chk("req_ready", req_ready, !pend);
            chk("mask", ram_data_mask, 0);
            exp_cmd = pend && !issued && !ram_busy;
            chk("cmd_en", ram_cmd_en, exp_cmd);
            if (exp_cmd) begin
                chk("cmd_addr", ram_addr, m_addr);
                chk("cmd_dir", ram_cmd, m_wr);
                issued = 1;
                issue_cyc = cyc;
                rd_cnt = 0;
                m_err = 0;
                done_cyc = m_wr ? cyc + BC : -1;
            end
            if (pend && issued && m_wr && (cyc - issue_cyc) < BC)
                chk($sformatf("wr_word%0d", cyc - issue_cyc), ram_wr_data,
                    m_line[(cyc - issue_cyc) * DW +: DW]);
            if (pend && issued && !m_wr && cyc > issue_cyc && done_cyc < 0) begin
                if (ram_rd_data_ready) begin
                    m_cap[rd_cnt * DW +: DW] = ram_rd_data;
                    rd_cnt++;
                    if (rd_cnt == BC) done_cyc = cyc + 1;
                end
`ifdef BURST_MASTER_TIMEOUT_EN
                else if (rd_cnt == 0 && (cyc - issue_cyc) == TO) begin
                    done_cyc = cyc + 1;
                    m_err = 1;
                end
`endif
            end
            exp_rv = pend && issued && (cyc == done_cyc);
            if (exp_rv && !m_wr && !m_err) begin
                m_resp_line = m_cap;
                chk("rd_line_vs_mem", m_cap, m_exp_rd);
            end
            chk("resp_valid", resp_valid, exp_rv);
            chk("resp_err", resp_err, exp_rv && m_err);
            chk("resp_line", resp_line, m_resp_line);
        end
        if (exp_rv) begin
            pend = 0;
        end else if (rst && !pend && req_valid) begin
            pend = 1;
            issued = 0;
            done_cyc = -1;
            m_wr = req_write;
            m_addr = (int'(req_addr) / BC) * BC;
            m_line = req_line;
            for (int i = 0; i < BC; i++) begin
                if (m_wr) ref_mem[m_addr + i] = req_line[i * DW +: DW];
                else m_exp_rd[i * DW +: DW] = ref_mem[m_addr + i];
            end
        end
        if (!rst) pend = 0;
        prev_rst = rst;
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 300);
        if (!req_ready) bound_fail(name);
    endtask

    // Issue one request and return cycles from command strobe to resp_valid.
    task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] line,
                           output int lat, output bit err);
        int n, cmd_at;
        @(posedge clk); #1;
        req_valid = 1; req_write = wr; req_addr = a; req_line = line;
        wait_ready("accept");
        @(posedge clk); #1;
        req_valid = 0;
        n = 0; cmd_at = -1; lat = -1; err = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (ram_cmd_en && cmd_at < 0) cmd_at = n;
            if (resp_valid) begin
                lat = n - cmd_at;
                err = resp_err;
                break;
            end
        end
        if (lat < 0) bound_fail("resp_wait");
    endtask

    // Two requests with req_valid held high across both.
    task automatic b2b(input bit wr1, input logic [AW-1:0] a1, input logic [LW-1:0] l1,
                       input bit wr2, input logic [AW-1:0] a2, input logic [LW-1:0] l2);
        int n, r, q;
        @(posedge clk); #1;
        req_valid = 1; req_write = wr1; req_addr = a1; req_line = l1;
        wait_ready("b2b_accept1");
        @(posedge clk); #1;
        req_write = wr2; req_addr = a2; req_line = l2;
        n = 0; r = -1; q = -1;
        while (q < 0 && n < 400) begin
            @(negedge clk);
            n++;
            if (resp_valid && r < 0) r = n;
            else if (req_ready && r >= 0) q = n;
        end
        if (q < 0) bound_fail("b2b_accept2");
        else chk("b2b_accept_gap", q - r, 1);
        @(posedge clk); #1;
        req_valid = 0;
        n = 0;
        while (!resp_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) bound_fail("b2b_resp2");
    endtask

    logic [LW-1:0] line_a, line_b, line_c;
    logic [DW-1:0] saved [4];
    int            lat, cnt;
    bit            err;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = {$urandom, $urandom};
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < BC; i++) line_a[i * DW +: DW] = 64'h11 * (i + 1);
        repeat (3) @(posedge clk);
        #1 rst = 1;

        // write under initial busy, then read it back
        run_txn(1, 4'd4, line_a, lat, err);
        chk("wr_latency", lat, BC);
        for (int i = 0; i < BC; i++) chk($sformatf("ram[%0d]", 4 + i), mem[4 + i], 64'h11 * (i + 1));
        run_txn(0, 4'd4, '0, lat, err);
        chk("rd_line_literal", resp_line, {64'h44, 64'h33, 64'h22, 64'h11});
        chk("rd_err", err, 0);

        // unaligned write lands on the aligned burst
        for (int i = 0; i < 4; i++) saved[i] = mem[i];
        for (int i = 0; i < BC; i++) line_b[i * DW +: DW] = 64'hA0 + i;
        run_txn(1, 4'd14, line_b, lat, err);
        for (int i = 0; i < BC; i++) chk($sformatf("ram[%0d]", 12 + i), mem[12 + i], 64'hA0 + i);
        for (int i = 0; i < 4; i++) chk($sformatf("ram_untouched[%0d]", i), mem[i], saved[i]);

        // back-to-back write then read of addr 0
        for (int i = 0; i < BC; i++) line_c[i * DW +: DW] = {$urandom, $urandom};
        b2b(1, 4'd0, line_c, 0, 4'd0, '0);
        chk("b2b_read_line", resp_line, line_c);

        // reset in the 2nd RD_BURST cycle
        no_gap = 1;
        @(posedge clk); #1;
        req_valid = 1; req_write = 0; req_addr = 4'd4;
        wait_ready("abort_accept");
        @(posedge clk); #1;
        req_valid = 0;
        cnt = 0;
        while (!ram_cmd_en && cnt < 300) begin @(negedge clk); cnt++; end
        do begin @(negedge clk); cnt++; end while (!ram_rd_data_ready && cnt < 300);
        if (cnt >= 300) bound_fail("abort_first_word");
        @(posedge clk); #1;            // RD_BURST, 1st cycle
        @(posedge clk); #1 rst = 0;    // RD_BURST, 2nd cycle
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        chk("req_ready_after_rst", req_ready, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) cnt++;
            @(negedge clk);
        end
        chk("no_resp_after_abort", cnt, 0);
        no_gap = 0;

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < BC; i++) line_a[i * DW +: DW] = {$urandom, $urandom};
            for (int i = 0; i < BC; i++) line_b[i * DW +: DW] = {$urandom, $urandom};
            if ($urandom_range(3) == 0)
                b2b($urandom_range(1), 4'($urandom_range(15)), line_a,
                    $urandom_range(1), 4'($urandom_range(15)), line_b);
            else
                run_txn($urandom_range(1), 4'($urandom_range(15)), line_a, lat, err);
            repeat ($urandom_range(3)) @(posedge clk);
        end

`ifdef BURST_MASTER_TIMEOUT_EN
        force_no_rd = 1;
        line_a = resp_line;
        run_txn(0, 4'd8, '0, lat, err);
        chk("timeout_latency", lat, TO + 1);
        chk("timeout_err", err, 1);
        chk("timeout_line_kept", resp_line, line_a);
        force_no_rd = 0;
        rd_left = 0;
        run_txn(0, 4'd8, '0, lat, err);
        chk("after_timeout_err", err, 0);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
